// File: rtl/claswp_call_sequencer.sv
// Queues claswp call descriptors and runs them one at a time on the component.
// Each result is returned with its caller tag and the number of run cycles it took.
module claswp_call_sequencer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [TAG_W-1:0] job_tag,
   input  logic [447:0]     job_args,
   output logic             cmp_start,
   input  logic             cmp_busy,
   output logic [63:0]      cmp_n,
   output logic [63:0]      cmp_a,
   output logic [63:0]      cmp_lda,
   output logic [63:0]      cmp_k1,
   output logic [63:0]      cmp_k2,
   output logic [63:0]      cmp_ipiv,
   output logic [63:0]      cmp_incx,
   input  logic             cmp_done,
   output logic             cmp_stall,
   input  logic [31:0]      cmp_returndata,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic [31:0]      res_cycles,
   output logic [4:0]       pending,
   output logic [1:0]       fsm_state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int EW = TAG_W + 448;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALL = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t             state;
   logic [EW-1:0]      mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               ready_q;
   logic [TAG_W-1:0]   tag_q;
   logic [447:0]       args_q;
   logic [31:0]        cyc;
   logic [31:0]        cyc_next;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   // ready_q keeps job_ready low while reset is held and for no longer.
   assign job_ready = ready_q & ~full;
   assign push  = job_valid & job_ready;
   // The head leaves the FIFO only when the sequencer can take it next cycle.
   assign pop   = ~empty & ((state == IDLE) | ((state == RESP) & res_ready));

   assign cyc_next = (cyc == 32'hFFFF_FFFF) ? cyc : cyc + 32'd1;

   assign cmp_start = (state == CALL);
   assign cmp_stall = (state != RUN);
   assign res_valid = (state == RESP);
   assign fsm_state = state;
   assign pending   = 5'(count) + {4'd0, (state != IDLE)};

   assign cmp_n    = args_q[63:0];
   assign cmp_a    = args_q[127:64];
   assign cmp_lda  = args_q[191:128];
   assign cmp_k1   = args_q[255:192];
   assign cmp_k2   = args_q[319:256];
   assign cmp_ipiv = args_q[383:320];
   assign cmp_incx = args_q[447:384];

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {job_tag, job_args};
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         tag_q      <= '0;
         args_q     <= '0;
         cyc        <= '0;
         res_data   <= '0;
         res_tag    <= '0;
         res_cycles <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  {tag_q, args_q} <= mem[rd_ptr];
                  state           <= CALL;
               end
            end
            CALL: begin
               if (!cmp_busy) begin
                  cyc   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               // The done cycle itself counts as a run cycle.
               if (cmp_done) begin
                  res_data   <= cmp_returndata;
                  res_tag    <= tag_q;
                  res_cycles <= cyc_next;
                  state      <= RESP;
               end else begin
                  cyc <= cyc_next;
               end
            end
            RESP: begin
               if (res_ready) begin
                  if (pop) begin
                     {tag_q, args_q} <= mem[rd_ptr];
                     state           <= CALL;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_claswp_call_sequencer.sv
// Directed bench: a responder models the component, a monitor scores results and
// call arguments against an expected queue filled when jobs are pushed.
module tb_claswp_call_sequencer;

   localparam int EW = 4 + 448 + 32 + 32;

   logic         clock = 1'b0;
   logic         resetn;
   logic         job_valid;
   logic         job_ready;
   logic [3:0]   job_tag;
   logic [447:0] job_args;
   logic         cmp_start;
   logic         cmp_busy;
   logic [63:0]  cmp_n, cmp_a, cmp_lda, cmp_k1, cmp_k2, cmp_ipiv, cmp_incx;
   logic         cmp_done;
   logic         cmp_stall;
   logic [31:0]  cmp_returndata;
   logic         res_valid;
   logic         res_ready;
   logic [31:0]  res_data;
   logic [3:0]   res_tag;
   logic [31:0]  res_cycles;
   logic [4:0]   pending;
   logic [1:0]   fsm_state;

   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int accepts = 0;
   int busy_cfg = 0;
   int done_cfg = 1;
   int stray_req = 0;
   int stray_ack = 0;
   bit stray_in_call = 0;

   claswp_call_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
      .clock(clock), .resetn(resetn),
      .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag), .job_args(job_args),
      .cmp_start(cmp_start), .cmp_busy(cmp_busy),
      .cmp_n(cmp_n), .cmp_a(cmp_a), .cmp_lda(cmp_lda), .cmp_k1(cmp_k1),
      .cmp_k2(cmp_k2), .cmp_ipiv(cmp_ipiv), .cmp_incx(cmp_incx),
      .cmp_done(cmp_done), .cmp_stall(cmp_stall), .cmp_returndata(cmp_returndata),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_tag(res_tag), .res_cycles(res_cycles), .pending(pending), .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [447:0] mk_args(input logic [63:0] n);
      return {n + 64'h6000, n + 64'h5000, n + 64'h4000, n + 64'h3000,
              n + 64'h2000, n + 64'h1000_0000, n};
   endfunction

   task automatic push_job(input logic [3:0] tag, input logic [63:0] n,
                           input logic [31:0] exp_data, input logic [31:0] exp_cyc,
                           input bit expect_res);
      int w = 0;
      while (!job_ready && w < 300) begin
         @(negedge clock);
         w++;
      end
      if (!job_ready) chk("push_ready_timeout", 448'(job_ready), 448'(1));
      job_valid = 1'b1;
      job_tag   = tag;
      job_args  = mk_args(n);
      if (expect_res) exp_q.push_back({tag, mk_args(n), exp_data, exp_cyc});
      @(negedge clock);
      job_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int w = 0;
      while (exp_q.size() > 0 && w < budget) begin
         @(negedge clock);
         w++;
      end
      chk("drain_left", 448'(exp_q.size()), 448'(0));
   endtask

   // Component model: holds busy for busy_cfg cycles, then raises done on the
   // done_cfg-th run cycle with returndata = n[31:0] + 0x1000.
   initial begin
      cmp_busy = 1'b0;
      cmp_done = 1'b0;
      cmp_returndata = '0;
      forever begin
         @(negedge clock);
         if (stray_req != stray_ack) begin
            cmp_returndata = 32'hDEAD_BEEF;
            cmp_done = 1'b1;
            @(negedge clock);
            cmp_done = 1'b0;
            stray_ack++;
         end else if (cmp_start) begin
            cmp_busy = (busy_cfg > 0);
            if (stray_in_call) begin
               cmp_returndata = 32'hBAD0_0000;
               cmp_done = 1'b1;
            end
            repeat (busy_cfg) begin
               @(negedge clock);
               cmp_done = 1'b0;
            end
            cmp_busy = 1'b0;
            @(negedge clock);
            repeat (done_cfg - 1) @(negedge clock);
            cmp_returndata = cmp_n[31:0] + 32'h1000;
            cmp_done = 1'b1;
            @(negedge clock);
            cmp_done = 1'b0;
         end
      end
   end

   // Monitor: arguments while the call is active, results while res_valid.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (resetn) begin
            if (cmp_start && !cmp_busy) accepts++;
            if ((cmp_start || !cmp_stall) && exp_q.size() > 0)
               chk("cmp_args", {cmp_incx, cmp_ipiv, cmp_k2, cmp_k1, cmp_lda, cmp_a, cmp_n},
                   exp_q[0][511:64]);
            if (res_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", 448'(res_valid), 448'(0));
               end else begin
                  chk("res_tag", 448'(res_tag), 448'(exp_q[0][515:512]));
                  chk("res_data", 448'(res_data), 448'(exp_q[0][63:32]));
                  chk("res_cycles", 448'(res_cycles), 448'(exp_q[0][31:0]));
                  if (res_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int w;
      int acc0;
      int seen;
      resetn = 1'b0;
      job_valid = 1'b0;
      job_tag = '0;
      job_args = '0;
      res_ready = 1'b1;

      // Reset values
      repeat (3) @(negedge clock);
      chk("rst_job_ready", 448'(job_ready), 448'(0));
      chk("rst_cmp_start", 448'(cmp_start), 448'(0));
      chk("rst_cmp_stall", 448'(cmp_stall), 448'(1));
      chk("rst_res_valid", 448'(res_valid), 448'(0));
      chk("rst_res_data", 448'(res_data), 448'(0));
      chk("rst_res_tag", 448'(res_tag), 448'(0));
      chk("rst_res_cycles", 448'(res_cycles), 448'(0));
      chk("rst_pending", 448'(pending), 448'(0));
      chk("rst_args", {cmp_incx, cmp_ipiv, cmp_k2, cmp_k1, cmp_lda, cmp_a, cmp_n}, 448'(0));
      resetn = 1'b1;
      @(negedge clock);
      chk("job_ready_after_rst", 448'(job_ready), 448'(1));

      // Single job: busy 2, done on 10th run cycle
      busy_cfg = 2;
      done_cfg = 10;
      acc0 = accepts;
      push_job(4'd3, 64'd8, 32'h0000_1008, 32'd10, 1'b1);
      w = 0;
      while (!cmp_start && w < 20) begin @(negedge clock); w++; end
      chk("call_start_seen", 448'(cmp_start), 448'(1));
      chk("call_stall", 448'(cmp_stall), 448'(1));
      w = 0;
      while (cmp_start && w < 20) begin @(negedge clock); w++; end
      chk("run_stall", 448'(cmp_stall), 448'(0));
      drain(60);
      chk("single_accepts", 448'(accepts - acc0), 448'(1));
      @(negedge clock);
      chk("idle_pending", 448'(pending), 448'(0));

      // DEPTH+1 back-to-back jobs while the component is busy
      busy_cfg = 12;
      done_cfg = 3;
      for (int i = 0; i < 5; i++)
         push_job(4'(i + 1), 64'h40 + 64'(i), 32'h1040 + 32'(i), 32'd3, 1'b1);
      chk("full_job_ready", 448'(job_ready), 448'(0));
      chk("full_pending", 448'(pending), 448'(5));
      busy_cfg = 1;
      push_job(4'd6, 64'h45, 32'h0000_1045, 32'd3, 1'b1);
      drain(200);

      // Result held for 20 cycles with a job queued behind it
      busy_cfg = 0;
      done_cfg = 2;
      res_ready = 1'b0;
      push_job(4'd7, 64'h20, 32'h0000_1020, 32'd2, 1'b1);
      push_job(4'd8, 64'h21, 32'h0000_1021, 32'd2, 1'b1);
      w = 0;
      while (!res_valid && w < 30) begin @(negedge clock); w++; end
      chk("hold_res_valid", 448'(res_valid), 448'(1));
      repeat (20) begin
         @(negedge clock);
         chk("hold_cmp_start", 448'(cmp_start), 448'(0));
         chk("hold_pending", 448'(pending), 448'(2));
      end
      res_ready = 1'b1;
      @(negedge clock);
      chk("release_call", 448'(cmp_start), 448'(1));
      chk("release_pending", 448'(pending), 448'(1));
      drain(40);

      // Stray done pulses in IDLE and in CALL
      stray_req++;
      repeat (4) @(negedge clock);
      chk("stray_idle_res_valid", 448'(res_valid), 448'(0));
      chk("stray_idle_state", 448'(fsm_state), 448'(0));
      stray_in_call = 1'b1;
      busy_cfg = 2;
      done_cfg = 4;
      push_job(4'd9, 64'h30, 32'h0000_1030, 32'd4, 1'b1);
      drain(40);
      stray_in_call = 1'b0;

      // Reset during RUN with two jobs queued
      busy_cfg = 0;
      done_cfg = 40;
      push_job(4'd10, 64'h50, 32'd0, 32'd0, 1'b0);
      push_job(4'd11, 64'h51, 32'd0, 32'd0, 1'b0);
      push_job(4'd12, 64'h52, 32'd0, 32'd0, 1'b0);
      w = 0;
      while (cmp_stall && w < 20) begin @(negedge clock); w++; end
      chk("pre_rst_run", 448'(cmp_stall), 448'(0));
      repeat (2) @(negedge clock);
      chk("pre_rst_pending", 448'(pending), 448'(3));
      resetn = 1'b0;
      #1;
      chk("midrst_pending", 448'(pending), 448'(0));
      chk("midrst_job_ready", 448'(job_ready), 448'(0));
      chk("midrst_cmp_start", 448'(cmp_start), 448'(0));
      chk("midrst_cmp_stall", 448'(cmp_stall), 448'(1));
      chk("midrst_res_valid", 448'(res_valid), 448'(0));
      chk("midrst_res_data", 448'(res_data), 448'(0));
      chk("midrst_res_tag", 448'(res_tag), 448'(0));
      chk("midrst_res_cycles", 448'(res_cycles), 448'(0));
      chk("midrst_args", {cmp_incx, cmp_ipiv, cmp_k2, cmp_k1, cmp_lda, cmp_a, cmp_n}, 448'(0));
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      seen = 0;
      repeat (60) begin
         @(negedge clock);
         if (res_valid || cmp_start) seen++;
      end
      chk("post_rst_no_activity", 448'(seen), 448'(0));
      chk("post_rst_pending", 448'(pending), 448'(0));
      chk("post_rst_job_ready", 448'(job_ready), 448'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/claswp_call_sequencer.md
CLASWP_CALL_SEQUENCER -- requirements
Module: claswp_call_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: descriptor FIFO entries, power of two, 2..16.
REQ-002 Parameter TAG_W, default 4: job tag width.
REQ-003 Port: clock  input  1  sole clock, all state rising-edge.
REQ-004 Port: resetn  input  1  asynchronous active-low reset.
REQ-005 Port: job_valid  input  1  descriptor offered.
REQ-006 Port: job_ready  output  1  descriptor accepted when job_valid & job_ready.
REQ-007 Port: job_tag  input  TAG_W  caller tag, returned with result.
REQ-008 Port: job_args  input  448  {incx,ipiv,k2,k1,lda,a,n}, 64 bits each, n in [63:0].
REQ-009 Port: cmp_start  output  1  to component call.valid.
REQ-010 Port: cmp_busy  input  1  from component call.stall.
REQ-011 Port: cmp_n, cmp_a, cmp_lda, cmp_k1, cmp_k2, cmp_ipiv, cmp_incx  output  64 each  component arguments.
REQ-012 Port: cmp_done  input  1  from component return.valid.
REQ-013 Port: cmp_stall  output  1  to component return.stall.
REQ-014 Port: cmp_returndata  input  32  component return data.
REQ-015 Port: res_valid  output  1  result available.
REQ-016 Port: res_ready  input  1  result consumed when res_valid & res_ready.
REQ-017 Port: res_data  output  32  captured returndata.
REQ-018 Port: res_tag  output  TAG_W  tag of the job that produced res_data.
REQ-019 Port: res_cycles  output  32  cycles from call acceptance to done, saturating.
REQ-020 Port: pending  output  5  FIFO occupancy plus the in-flight job.

Function
REQ-021 Descriptor FIFO of DEPTH entries (tag+args); job_ready = FIFO not full; full and simultaneous push/pop handled, pointers wrap modulo DEPTH.
REQ-022 FSM states IDLE, CALL, RUN, RESP; exactly one component invocation in flight.
REQ-023 IDLE: FIFO non-empty -> pop head into argument/tag registers, go to CALL next cycle; else stay.
REQ-024 CALL: cmp_start=1; arguments driven from registers; call accepted on cycle with cmp_start & !cmp_busy -> RUN.
REQ-025 cmp_start not deasserted and arguments not changed while in CALL (no abort).
REQ-026 Arguments held stable from CALL entry until leaving RUN.
REQ-027 RUN: cmp_stall=0; on cmp_done=1, capture cmp_returndata, tag and cycle count into res_* registers -> RESP.
REQ-028 cmp_stall=1 in every state except RUN; cmp_done outside RUN ignored.
REQ-029 Cycle counter cleared on the accepting cycle, +1 each RUN cycle, value at cmp_done equals RUN cycles including the done cycle; saturates at 0xFFFFFFFF.
REQ-030 RESP: res_valid=1, res_* stable; on res_ready -> IDLE, or directly CALL with next head popped if FIFO non-empty (zero-bubble).
REQ-031 pending = FIFO count + (state != IDLE); job push and pop in same cycle leave count unchanged.
REQ-032 Results returned in descriptor acceptance order.

Reset
REQ-033 resetn low: state IDLE, FIFO empty, job_ready=0 during reset and 1 first cycle after, cmp_start=0, cmp_stall=1, res_valid=0, res_data=0, res_tag=0, res_cycles=0, pending=0, argument registers 0.
REQ-034 Reset mid-job discards FIFO and in-flight job; no result produced for it.

Verification
REQ-035 Single job tag 3, n=8; component busy 2 cycles, done 10 cycles after accept -> one start accept, res_tag=3, res_data=returndata, res_cycles=10.
REQ-036 Push DEPTH+1 jobs back-to-back with component busy -> job_ready low after DEPTH+... (FIFO full), pending=DEPTH+1, results tags in push order.
REQ-037 res_ready held low 20 cycles in RESP -> res_* stable, cmp_start=0, next job not called; on release next call starts same cycle as pop.
REQ-038 cmp_done pulsed while in IDLE/CALL -> ignored, no result.
REQ-039 Assert resetn low during RUN with 2 jobs queued -> all outputs at reset values, pending=0, no res_valid afterward.
REQ-040 Argument check: cmp_a..cmp_incx equal pushed job_args fields and unchanged every cycle from CALL through done.
